// File: rtl/fifo_wr_arbiter_if.sv
// Handshake bundle between the requesters, the arbiter and the shared FIFO write port.
// The slave modport is the arbiter's view; the master modport is the requester/FIFO side.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32
);
  localparam int ID_W = (NUM_REQ == 1) ? 1 : $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     fifo_full;
  logic                     fifo_wen;
  logic [WIDTH-1:0]         fifo_in;
  logic [ID_W-1:0]          gnt_id;

  modport slave (
    input  req_valid, req_data, fifo_full,
    output req_ready, fifo_wen, fifo_in, gnt_id
  );

  modport master (
    output req_valid, req_data, fifo_full,
    input  req_ready, fifo_wen, fifo_in, gnt_id
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter with bounded burst hold, muxing NUM_REQ writers onto one FIFO write port.
// Grants are combinational in the request cycle; state advances on each rising edge.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 32,
  parameter int MAX_BURST = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  fifo_wr_arbiter_if.slave bus
);
  localparam int ID_W  = (NUM_REQ == 1) ? 1 : $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  logic [ID_W-1:0]    r_rr_ptr;
  logic [ID_W-1:0]    r_last_id;
  logic               r_last_vld;
  logic [CNT_W-1:0]   r_burst_cnt;

  logic               w_block;
  logic               w_hold;
  logic               w_rr_found;
  logic [ID_W-1:0]    w_rr_id;
  logic               w_gnt_vld;
  logic [ID_W-1:0]    w_gnt_id;
  logic [ID_W-1:0]    w_ptr_next;
  logic [CNT_W-1:0]   w_cnt_next;
  logic [NUM_REQ-1:0] w_ready;
  logic [WIDTH-1:0]   w_masked [NUM_REQ];
  logic [WIDTH-1:0]   w_data;

  // rst is folded in so every output is quiet during a reset cycle.
  assign w_block = rst | flush | bus.fifo_full | ~(|bus.req_valid);
  assign w_hold  = r_last_vld && bus.req_valid[r_last_id] &&
                   (r_burst_cnt < CNT_W'(MAX_BURST));

  always_comb begin : rr_search
    int v_idx;
    w_rr_found = 1'b0;
    w_rr_id    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      v_idx = int'(r_rr_ptr) + k;
      if (v_idx >= NUM_REQ) v_idx = v_idx - NUM_REQ;
      if (!w_rr_found && bus.req_valid[v_idx]) begin
        w_rr_found = 1'b1;
        w_rr_id    = ID_W'(v_idx);
      end
    end
  end

  assign w_gnt_vld = ~w_block & (w_hold | w_rr_found);
  assign w_gnt_id  = w_gnt_vld ? (w_hold ? r_last_id : w_rr_id) : '0;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_port
      assign w_ready[gi]  = w_gnt_vld && (w_gnt_id == ID_W'(gi));
      assign w_masked[gi] = bus.req_data[gi*WIDTH +: WIDTH] & {WIDTH{w_ready[gi]}};
    end
  endgenerate

  always_comb begin
    w_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_data = w_data | w_masked[i];
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.fifo_wen  = w_gnt_vld;
  assign bus.fifo_in   = w_data;
  assign bus.gnt_id    = w_gnt_id;

  assign w_ptr_next = (int'(w_gnt_id) == NUM_REQ - 1) ? '0 : ID_W'(int'(w_gnt_id) + 1);

  // Repeat grants to the same winner count up and saturate; a new winner restarts at 1.
  always_comb begin
    w_cnt_next = CNT_W'(1);
    if (r_last_vld && (r_last_id == w_gnt_id)) begin
      if (r_burst_cnt < CNT_W'(MAX_BURST)) w_cnt_next = r_burst_cnt + CNT_W'(1);
      else                                 w_cnt_next = r_burst_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_rr_ptr    <= '0;
      r_last_id   <= '0;
      r_last_vld  <= 1'b0;
      r_burst_cnt <= '0;
    end else if (w_gnt_vld) begin
      r_rr_ptr    <= w_ptr_next;
      r_last_id   <= w_gnt_id;
      r_last_vld  <= 1'b1;
      r_burst_cnt <= w_cnt_next;
    end else begin
      r_last_vld  <= 1'b0;
      r_burst_cnt <= '0;
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed, table-driven check of fifo_wr_arbiter with NUM_REQ=4, WIDTH=32, MAX_BURST=2.
// Each vector is one clock cycle: inputs driven after the falling edge, outputs checked 1ns later.
module tb_fifo_wr_arbiter;
  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 32;

  typedef struct {
    logic       rst;
    logic       flush;
    logic       full;
    logic [3:0] valid;
    int         gnt;
    logic       wen;
  } vec_t;

  logic clk;
  logic rst;
  logic flush;
  int   n_checks;
  int   n_fail;
  vec_t vecs[$];

  fifo_wr_arbiter_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) bus ();

  fifo_wr_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .MAX_BURST(2)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] slice_val(int i);
    return 32'h1000_0000 * (i + 1) + 32'h00AB_CD00 + i;
  endfunction

  task automatic add(logic r, logic f, logic fu, logic [3:0] v, int g, logic w);
    vec_t e;
    e.rst = r; e.flush = f; e.full = fu; e.valid = v; e.gnt = g; e.wen = w;
    vecs.push_back(e);
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(int idx, vec_t v);
    logic [3:0]  exp_ready;
    logic [31:0] exp_data;
    @(negedge clk);
    rst           = v.rst;
    flush         = v.flush;
    bus.fifo_full = v.full;
    bus.req_valid = v.valid;
    #1;
    exp_ready = v.wen ? (4'b0001 << v.gnt) : 4'b0000;
    exp_data  = v.wen ? slice_val(v.gnt) : 32'h0;
    check($sformatf("v%0d req_ready", idx), {28'h0, bus.req_ready}, {28'h0, exp_ready});
    check($sformatf("v%0d fifo_wen", idx), {31'h0, bus.fifo_wen}, {31'h0, v.wen});
    check($sformatf("v%0d gnt_id", idx), {30'h0, bus.gnt_id}, v.wen ? v.gnt : 0);
    check($sformatf("v%0d fifo_in", idx), bus.fifo_in, exp_data);
    check($sformatf("v%0d ready_legal", idx),
          {31'h0, ($onehot0(bus.req_ready) && ((bus.req_ready & ~v.valid) == 4'b0))}, 32'h1);
    $display("vec %0d rst=%0b flush=%0b full=%0b valid=%b -> ready=%b wen=%0b gnt=%0d in=%h",
             idx, v.rst, v.flush, v.full, v.valid, bus.req_ready, bus.fifo_wen,
             bus.gnt_id, bus.fifo_in);
  endtask

  task automatic step(logic r, logic f, logic fu, logic [3:0] v, int g, logic w);
    vec_t e;
    e.rst = r; e.flush = f; e.full = fu; e.valid = v; e.gnt = g; e.wen = w;
    run_vec(1000 + n_checks / 5, e);
  endtask

  initial begin
    clk           = 1'b0;
    rst           = 1'b1;
    flush         = 1'b0;
    n_checks      = 0;
    n_fail        = 0;
    bus.fifo_full = 1'b0;
    bus.req_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) bus.req_data[i*WIDTH +: WIDTH] = slice_val(i);

    // Reset state with everyone requesting, then full contention with burst of 2.
    add(1, 0, 0, 4'b1111, 0, 0);
    add(0, 0, 0, 4'b1111, 0, 1); add(0, 0, 0, 4'b1111, 0, 1);
    add(0, 0, 0, 4'b1111, 1, 1); add(0, 0, 0, 4'b1111, 1, 1);
    add(0, 0, 0, 4'b1111, 2, 1); add(0, 0, 0, 4'b1111, 2, 1);
    add(0, 0, 0, 4'b1111, 3, 1); add(0, 0, 0, 4'b1111, 3, 1);
    add(0, 0, 0, 4'b1111, 0, 1); add(0, 0, 0, 4'b1111, 0, 1);
    // Lone requester 2 streams without bubbles.
    add(1, 0, 0, 4'b0100, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 0, 0, 4'b0100, 2, 1);
    // FIFO full in cycles 3-5 clears the burst; pointer resumes at 2.
    add(1, 0, 0, 4'b1111, 0, 0);
    add(0, 0, 0, 4'b1111, 0, 1); add(0, 0, 0, 4'b1111, 0, 1);
    add(0, 0, 0, 4'b1111, 1, 1);
    add(0, 0, 1, 4'b1111, 0, 0); add(0, 0, 1, 4'b1111, 0, 0); add(0, 0, 1, 4'b1111, 0, 0);
    add(0, 0, 0, 4'b1111, 2, 1); add(0, 0, 0, 4'b1111, 2, 1);
    add(0, 0, 0, 4'b1111, 3, 1);
    // Flush in cycle 4 returns the pointer to 0.
    add(1, 0, 0, 4'b1111, 0, 0);
    add(0, 0, 0, 4'b1111, 0, 1); add(0, 0, 0, 4'b1111, 0, 1);
    add(0, 0, 0, 4'b1111, 1, 1); add(0, 0, 0, 4'b1111, 1, 1);
    add(0, 1, 0, 4'b1111, 0, 0);
    add(0, 0, 0, 4'b1111, 0, 1); add(0, 0, 0, 4'b1111, 0, 1);
    add(0, 0, 0, 4'b1111, 1, 1);
    // Sparse requesters: pointer wraps from 3 back to 0.
    add(1, 0, 0, 4'b1001, 0, 0);
    add(0, 0, 0, 4'b1001, 0, 1); add(0, 0, 0, 4'b1001, 0, 1);
    add(0, 0, 0, 4'b1001, 3, 1); add(0, 0, 0, 4'b1001, 3, 1);
    add(0, 0, 0, 4'b1001, 0, 1); add(0, 0, 0, 4'b1001, 0, 1);
    // Reset mid-burst after one grant to 1, then an idle cycle breaking a burst.
    add(1, 0, 0, 4'b0000, 0, 0);
    add(0, 0, 0, 4'b0010, 1, 1);
    add(1, 0, 0, 4'b1111, 0, 0);
    add(0, 0, 0, 4'b1111, 0, 1); add(0, 0, 0, 4'b1111, 0, 1);
    add(0, 0, 0, 4'b1111, 1, 1);
    add(0, 0, 0, 4'b0000, 0, 0);
    add(0, 0, 0, 4'b1111, 2, 1);

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Burst counter saturates on a lone requester, then a newcomer wins immediately.
    step(1, 1, 0, 4'b0001, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 4'b0001, 0, 1);
    step(0, 0, 0, 4'b0011, 1, 1);
    step(0, 0, 0, 4'b0011, 1, 1);
    step(0, 0, 0, 4'b0011, 0, 1);
    // Full stalls a hold candidate; afterwards round-robin from pointer 1 wins.
    step(0, 0, 1, 4'b0011, 0, 0);
    step(0, 0, 0, 4'b0011, 1, 1);
    step(0, 0, 0, 4'b0011, 1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
